// File: rtl/move_sequencer_if.sv
// ============================================================================
//  move_sequencer_if : command bus from the host decoder into move_sequencer
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface move_sequencer_if;
    logic               cmd_valid;
    logic               cmd_ready;
    logic signed [31:0] cmd_num_x;
    logic signed [31:0] cmd_num_y;
    logic signed [31:0] cmd_num_z;
    logic signed [31:0] cmd_num_e0;
    logic signed [31:0] cmd_num_e1;
    logic        [31:0] cmd_speed_x;
    logic        [31:0] cmd_speed_y;
    logic        [31:0] cmd_speed_z;
    logic        [31:0] cmd_speed_e0;
    logic        [31:0] cmd_speed_e1;

    modport master (
        output cmd_valid, cmd_num_x, cmd_num_y, cmd_num_z, cmd_num_e0, cmd_num_e1,
               cmd_speed_x, cmd_speed_y, cmd_speed_z, cmd_speed_e0, cmd_speed_e1,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_num_x, cmd_num_y, cmd_num_z, cmd_num_e0, cmd_num_e1,
               cmd_speed_x, cmd_speed_y, cmd_speed_z, cmd_speed_e0, cmd_speed_e1,
        output cmd_ready
    );
endinterface

`default_nettype wire

// File: rtl/move_sequencer.sv
// ============================================================================
//  move_sequencer : buffers move commands and sequences calc -> execute -> clear
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module move_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  wire                   clk,
    input  wire                   reset,
    input  wire                   abort,
    move_sequencer_if.slave       cmd,
    output logic signed [31:0]    mv_num_x,
    output logic signed [31:0]    mv_num_y,
    output logic signed [31:0]    mv_num_z,
    output logic signed [31:0]    mv_num_e0,
    output logic signed [31:0]    mv_num_e1,
    output logic        [31:0]    mv_speed_x,
    output logic        [31:0]    mv_speed_y,
    output logic        [31:0]    mv_speed_z,
    output logic        [31:0]    mv_speed_e0,
    output logic        [31:0]    mv_speed_e1,
    output logic                  stt_start,
    input  wire                   stt_finish,
    output logic                  stt_clear,
    output logic                  exec_start,
    input  wire                   exec_done,
    output logic                  exec_abort,
    output logic                  busy,
    output logic [$clog2(DEPTH):0] fill,
    output logic [CNT_W-1:0]      moves_done
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_cnt_full = (c_ptr_w+1)'(DEPTH);
    localparam logic [c_ptr_w:0]   c_cnt_one  = 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one  = 1;
    localparam logic [CNT_W-1:0]   c_done_one = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_RUN   = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t               r_state, w_next;
    logic                 r_retire, w_retire_next;
    logic                 r_run_first;
    logic [c_ptr_w-1:0]   r_rd_ptr, r_wr_ptr;
    logic [c_ptr_w:0]     r_count;
    logic [CNT_W-1:0]     r_moves_done;
    logic [319:0]         r_mv;
    logic [319:0]         r_mem [DEPTH];
    logic                 w_push, w_pop, w_load, w_full, w_head_zero;

    // Entry layout: {num x,y,z,e0,e1, speed x,y,z,e0,e1}, 32 bits each
    assign w_full      = (r_count == c_cnt_full);
    assign cmd.cmd_ready = !w_full && !abort;
    assign w_push      = cmd.cmd_valid && cmd.cmd_ready;
    assign w_pop       = (r_state == ST_CLEAR) && r_retire && !abort;
    assign w_head_zero = (r_mem[r_rd_ptr][319:160] == '0);

    always_comb begin
        w_next        = r_state;
        w_retire_next = r_retire;
        w_load        = 1'b0;
        stt_start     = 1'b0;
        stt_clear     = 1'b0;
        exec_start    = 1'b0;
        exec_abort    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_load = 1'b1;
                    if (w_head_zero) begin
                        w_next        = ST_CLEAR;
                        w_retire_next = 1'b1;
                    end else begin
                        w_next = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                stt_start = 1'b1;
                if (stt_finish) w_next = ST_RUN;
            end
            ST_RUN: begin
                exec_start = r_run_first;
                // exec_done may still be asserted from the previous move in the launch cycle
                if (!r_run_first && exec_done) begin
                    w_next        = ST_CLEAR;
                    w_retire_next = 1'b1;
                end
            end
            ST_CLEAR: begin
                stt_clear     = 1'b1;
                w_next        = ST_IDLE;
                w_retire_next = 1'b0;
            end
            default: w_next = ST_IDLE;
        endcase
        if (abort) begin
            w_next        = ST_CLEAR;
            w_retire_next = 1'b0;
            w_load        = 1'b0;
            exec_abort    = (r_state == ST_RUN);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_retire     <= 1'b0;
            r_run_first  <= 1'b0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_moves_done <= '0;
            r_mv         <= '0;
        end else begin
            r_state     <= w_next;
            r_retire    <= w_retire_next;
            r_run_first <= (w_next == ST_RUN) && (r_state != ST_RUN);
            if (w_load) r_mv <= r_mem[r_rd_ptr];
            if (abort) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
                if (w_pop) begin
                    r_rd_ptr     <= r_rd_ptr + c_ptr_one;
                    r_moves_done <= r_moves_done + c_done_one;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_cnt_one;
                    2'b01:   r_count <= r_count - c_cnt_one;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {cmd.cmd_num_x, cmd.cmd_num_y, cmd.cmd_num_z,
                                cmd.cmd_num_e0, cmd.cmd_num_e1,
                                cmd.cmd_speed_x, cmd.cmd_speed_y, cmd.cmd_speed_z,
                                cmd.cmd_speed_e0, cmd.cmd_speed_e1};
    end

    assign mv_num_x    = r_mv[319:288];
    assign mv_num_y    = r_mv[287:256];
    assign mv_num_z    = r_mv[255:224];
    assign mv_num_e0   = r_mv[223:192];
    assign mv_num_e1   = r_mv[191:160];
    assign mv_speed_x  = r_mv[159:128];
    assign mv_speed_y  = r_mv[127:96];
    assign mv_speed_z  = r_mv[95:64];
    assign mv_speed_e0 = r_mv[63:32];
    assign mv_speed_e1 = r_mv[31:0];

    assign busy       = (r_state != ST_IDLE) || (r_count != '0);
    assign fill       = r_count;
    assign moves_done = r_moves_done;

endmodule

`default_nettype wire

// File: doc/move_sequencer.md
# move_sequencer

Command-level scheduler between the host command decoder and the `speeds_to_timings` / step-generator datapath. It buffers up to DEPTH move commands and presents them one at a time to `speeds_to_timings`. It holds `start` until `finish`, then launches the step executor and waits for it to complete. It then clears the timing calculator and retires the move. Acceleration and jerk stay static configuration wired directly to `speeds_to_timings`; only per-move step counts and speeds pass through this block.

## Interface
- DEPTH, 4: command buffer entries; power of two, ≥2.
- CNT_W, 16: width of retired-move counter.

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- abort  in  1  synchronous flush request, level-sampled each cycle.
- cmd_valid  in  1  upstream command valid.
- cmd_ready  out  1  buffer can accept (`!full && !abort`).
- cmd_num_{x,y,z,e0,e1}  in  5×32 signed  step counts of the move.
- cmd_speed_{x,y,z,e0,e1}  in  5×32 unsigned  target speeds of the move.
- mv_num_{x,y,z,e0,e1}  out  5×32 signed  registered head move, to `speeds_to_timings` num_* inputs.
- mv_speed_{x,y,z,e0,e1}  out  5×32  registered head move, to speed_* inputs.
- stt_start  out  1  level start to `speeds_to_timings`.
- stt_finish  in  1  `speeds_to_timings` finish.
- stt_clear  out  1  one-cycle high pulse driving `speeds_to_timings` reset (active-high there).
- exec_start  out  1  one-cycle pulse: step executor loads params and runs.
- exec_done  in  1  executor move complete (pulse or level).
- exec_abort  out  1  one-cycle pulse: executor stops immediately.
- busy  out  1  state ≠ IDLE or fill ≠ 0.
- fill  out  $clog2(DEPTH)+1  entries in buffer, including the executing one.
- moves_done  out  CNT_W  moves retired; wraps modulo 2^CNT_W.

## Operation
- Buffer is a circular FIFO with registered rd/wr pointers and count. Push occurs on `cmd_valid && cmd_ready`. Pop occurs on retire only. The head entry stays in the FIFO until it is retired.
- Push and pop in the same cycle leave fill unchanged. There is no bypass: a command pushed into an empty FIFO is seen by the FSM the next cycle.
- FSM states: IDLE, CALC, RUN, CLEAR.
  - IDLE: if fill≠0, latch head into mv_*.
    - If all five head nums are 0, go to CLEAR with the retire flag set. Zero moves are retired without a calculation.
    - Otherwise go to CALC.
  - CALC: stt_start=1. On stt_finish=1 go to RUN; stt_start drops on the same edge.
  - RUN: exec_start=1 in the first RUN cycle only. exec_done is sampled from the second RUN cycle on. On exec_done, go to CLEAR with the retire flag set.
  - CLEAR: stt_clear=1 for exactly one cycle. If retire: pop and increment moves_done. Then go to IDLE.
- mv_* change only on the IDLE→CALC/CLEAR edge and are otherwise stable through CALC/RUN.
- Abort (highest priority, any state):
  - The next edge forces CLEAR with no retire.
  - The FIFO is flushed (fill=0, pointers equal).
  - exec_abort pulses if the FSM was in RUN.
  - stt_clear pulses in the CLEAR cycle.
  - A command offered during the abort cycle is not accepted (cmd_ready=0).
  - If abort is held, the FSM stays in CLEAR, pulsing stt_clear each cycle, until abort falls.
- stt_finish outside CALC and exec_done outside RUN are ignored.

## Timing
- Reset values (reset=0): state IDLE, fill 0, pointers 0, moves_done 0, mv_* 0, stt_start/stt_clear/exec_start/exec_abort 0, busy 0.
- cmd_ready is 1 once reset deasserts.
- Accept at edge E0 → state CALC and stt_start=1 after edge E1.
- stt_finish high in cycle k → exec_start high in cycle k+1 (single cycle).
- exec_done in cycle j → stt_clear high in cycle j+1 → IDLE in cycle j+2.
  - Fill decrements and moves_done increments after the edge ending cycle j+1.
  - If the FIFO is non-empty, the next stt_start is high in cycle j+3.
- Zero move: IDLE → CLEAR → IDLE, retired 2 cycles after reaching the head.
- Minimum per-move overhead beyond calculation and execution: 3 cycles (IDLE, first RUN, CLEAR).
- Full: cmd_ready=0 while fill==DEPTH. It rises one cycle after the retire edge.

## Test plan
- Single move x=2200,y=123,z=200,e0=532,e1=453, speeds 100; stt model finishes after 20 cycles, executor done after 50 → stt_start high 20 cycles, one exec_start pulse, one stt_clear, moves_done=1, fill=0, busy=0.
- Push 6 moves back-to-back with DEPTH=4 and a slow executor → exactly 4 accepted, cmd_ready=0 until the first retire. All accepted moves are presented in order with correct mv_* values. moves_done=4 at end.
- Zero move (all nums 0) between two normal moves → no stt_start/exec_start for it; moves_done increments by 3 in total.
- Abort during RUN with 3 moves queued → exec_abort and stt_clear pulse once, fill=0, moves_done unchanged, state IDLE two cycles later. A command offered in the abort cycle is dropped.
- Reset asserted mid-CALC → all outputs at reset values immediately (asynchronous). After release, the block is idle and accepts a new command normally.
- Spurious stt_finish in IDLE and exec_done during CALC → ignored; sequencing unchanged. Push and pop in the same cycle keep fill constant.
